// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: state encoding, fixed
// operand width, special-case result constants and sign helpers.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [DIV_WIDTH-1:0] INT_MIN       = 32'h8000_0000;

  // Controller states; RUN repeats once per quotient bit.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  // Two's-complement negation, truncated to the operand width, so that
  // negating INT_MIN yields INT_MIN again.
  function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] x);
    return ~x + 32'd1;
  endfunction

  // Magnitude of an operand. In signed mode |INT_MIN| comes out as
  // 8000_0000, which the datapath then treats as an unsigned value.
  function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] x,
                                                     input logic               isSigned);
    return (isSigned && x[DIV_WIDTH-1]) ? negate(x) : x;
  endfunction

endpackage

// File: rtl/seq_divider_adder_subtractor.sv
// ALU adder/subtractor reused by the divider for its trial subtraction.
// With sub_op_i = 1 it computes a - b as a + ~b + 1; carry_o = 1 then means
// "no borrow".
module adder_subtractor
  import seq_divider_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] a_i,
  input  logic [DIV_WIDTH-1:0] b_i,
  input  logic                 sub_op_i,
  output logic [DIV_WIDTH-1:0] result_o,
  output logic                 carry_o
);

  logic [DIV_WIDTH-1:0] bOperand;
  logic [DIV_WIDTH:0]   sumFull;

  // Single carry chain: invert b and inject the carry-in when subtracting.
  always_comb begin
    bOperand = sub_op_i ? ~b_i : b_i;
    sumFull  = {1'b0, a_i} + {1'b0, bOperand} + {{DIV_WIDTH{1'b0}}, sub_op_i};
  end

  assign result_o = sumFull[DIV_WIDTH-1:0];
  assign carry_o  = sumFull[DIV_WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle 32-bit restoring divider placed beside the ALU in EX.
// One quotient bit per cycle; the pipeline stalls while busy_o is high and
// picks up the quotient/remainder on the done_o pulse. Divide-by-zero and
// signed INT_MIN / -1 can optionally finish straight after PREP.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH     = DIV_WIDTH,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o,
  output logic             overflow_o
);

  // Controller state
  div_state_e state_q, state_d;

  // Operands as sampled on the accepted start
  logic [DIV_WIDTH-1:0] dividendRaw_q, dividendRaw_d;
  logic [DIV_WIDTH-1:0] divisorRaw_q,  divisorRaw_d;
  logic                 signed_q,      signed_d;

  // Working datapath: partial remainder, dividend/quotient shifter, divisor magnitude
  logic [DIV_WIDTH-1:0] remAcc_q,      remAcc_d;
  logic [DIV_WIDTH-1:0] quoShift_q,    quoShift_d;
  logic [DIV_WIDTH-1:0] divisorMag_q,  divisorMag_d;
  logic [4:0]           count_q,       count_d;
  logic                 qNeg_q,        qNeg_d;
  logic                 rNeg_q,        rNeg_d;
  logic                 div0_q,        div0_d;
  logic                 ovf_q,         ovf_d;

  // Result registers, held until the next completed division
  logic [DIV_WIDTH-1:0] quotient_q,    quotient_d;
  logic [DIV_WIDTH-1:0] remainder_q,   remainder_d;
  logic                 divByZero_q,   divByZero_d;
  logic                 overflow_q,    overflow_d;

  // Combinational helpers
  logic                 prepDiv0;
  logic                 prepOvf;
  logic                 earlyExit;
  logic [DIV_WIDTH:0]   remShift;
  logic [DIV_WIDTH-1:0] trialDiff;
  logic                 trialCarry;
  logic                 trialBorrow;
  logic [DIV_WIDTH-1:0] fixQuotient;
  logic [DIV_WIDTH-1:0] fixRemainder;
  logic [DIV_WIDTH-1:0] earlyQuotient;
  logic [DIV_WIDTH-1:0] earlyRemainder;

  // Special-case detection from the latched operands, evaluated during PREP.
  always_comb begin
    prepDiv0       = (divisorRaw_q == '0);
    prepOvf        = signed_q && (dividendRaw_q == INT_MIN) && (divisorRaw_q == {DIV_WIDTH{1'b1}});
    earlyExit      = EARLY_OUT && (prepDiv0 || prepOvf);
    earlyQuotient  = prepDiv0 ? DIV0_QUOTIENT : INT_MIN;
    earlyRemainder = prepDiv0 ? dividendRaw_q : '0;
  end

  // The 33-bit shifted partial remainder: the old remainder with the next
  // dividend bit appended. Its top bit set means it certainly exceeds the
  // 32-bit divisor, so the subtract succeeds regardless of the adder carry.
  always_comb begin
    remShift    = {remAcc_q, quoShift_q[DIV_WIDTH-1]};
    trialBorrow = ~(remShift[DIV_WIDTH] | trialCarry);
  end

  adder_subtractor u_trialSub (
    .a_i      (remShift[DIV_WIDTH-1:0]),
    .b_i      (divisorMag_q),
    .sub_op_i (1'b1),
    .result_o (trialDiff),
    .carry_o  (trialCarry)
  );

  // Sign correction at the end of a full-length run; divide-by-zero
  // overrides the arithmetic result with the architectural values.
  always_comb begin
    fixQuotient  = qNeg_q ? negate(quoShift_q) : quoShift_q;
    fixRemainder = rNeg_q ? negate(remAcc_q) : remAcc_q;
    if (div0_q) begin
      fixQuotient  = DIV0_QUOTIENT;
      fixRemainder = dividendRaw_q;
    end
  end

  // State register; reset aborts any division in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = PREP;
      PREP:    state_d = earlyExit ? DONE : RUN;
      RUN:     if (count_q == 5'd0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy covers PREP through FIX, done is the DONE cycle only.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      PREP, RUN, FIX: busy_o = 1'b1;
      DONE:           done_o = 1'b1;
      default:        ;
    endcase
  end

  // Datapath next-state: operand capture, magnitude setup, one
  // shift-subtract step per RUN cycle and result loading.
  always_comb begin
    dividendRaw_d = dividendRaw_q;
    divisorRaw_d  = divisorRaw_q;
    signed_d      = signed_q;
    remAcc_d      = remAcc_q;
    quoShift_d    = quoShift_q;
    divisorMag_d  = divisorMag_q;
    count_d       = count_q;
    qNeg_d        = qNeg_q;
    rNeg_d        = rNeg_q;
    div0_d        = div0_q;
    ovf_d         = ovf_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    divByZero_d   = divByZero_q;
    overflow_d    = overflow_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          dividendRaw_d = dividend_i;
          divisorRaw_d  = divisor_i;
          signed_d      = is_signed_i;
          divByZero_d   = 1'b0;
          overflow_d    = 1'b0;
        end
      end
      PREP: begin
        quoShift_d   = magnitude(dividendRaw_q, signed_q);
        divisorMag_d = magnitude(divisorRaw_q, signed_q);
        qNeg_d       = signed_q && (dividendRaw_q[DIV_WIDTH-1] ^ divisorRaw_q[DIV_WIDTH-1]);
        rNeg_d       = signed_q && dividendRaw_q[DIV_WIDTH-1];
        remAcc_d     = '0;
        count_d      = 5'd31;
        div0_d       = prepDiv0;
        ovf_d        = prepOvf;
        if (earlyExit) begin
          quotient_d  = earlyQuotient;
          remainder_d = earlyRemainder;
          divByZero_d = prepDiv0;
          overflow_d  = prepOvf;
        end
      end
      RUN: begin
        remAcc_d   = trialBorrow ? remShift[DIV_WIDTH-1:0] : trialDiff;
        quoShift_d = {quoShift_q[DIV_WIDTH-2:0], ~trialBorrow};
        count_d    = count_q - 5'd1;
      end
      FIX: begin
        quotient_d  = fixQuotient;
        remainder_d = fixRemainder;
        divByZero_d = div0_q;
        overflow_d  = ovf_q;
      end
      default: ;
    endcase
  end

  // Datapath and result registers; everything clears on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dividendRaw_q <= '0;
      divisorRaw_q  <= '0;
      signed_q      <= 1'b0;
      remAcc_q      <= '0;
      quoShift_q    <= '0;
      divisorMag_q  <= '0;
      count_q       <= '0;
      qNeg_q        <= 1'b0;
      rNeg_q        <= 1'b0;
      div0_q        <= 1'b0;
      ovf_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      divByZero_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      dividendRaw_q <= dividendRaw_d;
      divisorRaw_q  <= divisorRaw_d;
      signed_q      <= signed_d;
      remAcc_q      <= remAcc_d;
      quoShift_q    <= quoShift_d;
      divisorMag_q  <= divisorMag_d;
      count_q       <= count_d;
      qNeg_q        <= qNeg_d;
      rNeg_q        <= rNeg_d;
      div0_q        <= div0_d;
      ovf_q         <= ovf_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      divByZero_q   <= divByZero_d;
      overflow_q    <= overflow_d;
    end
  end

  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = divByZero_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        isSigned;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;
  logic        overflow;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int          lat;
    int          startCycle;
    int          id;
  } exp_t;

  exp_t sbQueue[$];
  exp_t popped;

  int cycleCnt    = 0;
  int doneSeen    = 0;
  int doneTarget  = 0;
  int assertCount = 0;
  int failCount   = 0;
  int busyBad     = 0;
  int baseline    = 0;

  seq_divider #(.EARLY_OUT(1'b1)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .is_signed_i   (isSigned),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .busy_o        (busy),
    .done_o        (done),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .div_by_zero_o (divByZero),
    .overflow_o    (overflow)
  );

  always #5 clk = ~clk;

  // Cycle k runs from posedge k to posedge k+1.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      doneSeen++;
      if (sbQueue.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpectedDone: got done at cycle %0d, expected none", cycleCnt);
      end else begin
        popped = sbQueue.pop_front();
        checkOutput($sformatf("vec%0d.quotient", popped.id), quotient, popped.q);
        checkOutput($sformatf("vec%0d.remainder", popped.id), remainder, popped.r);
        checkOutput($sformatf("vec%0d.flags", popped.id), {30'd0, divByZero, overflow}, {30'd0, popped.dz, popped.ov});
        checkOutput($sformatf("vec%0d.latency", popped.id), cycleCnt - popped.startCycle, popped.lat);
      end
    end
  end

  // Issue one start pulse (one cycle) and register its expected result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                               input logic [31:0] expQ, input logic [31:0] expR,
                               input logic expDz, input logic expOv, input int lat, input int id);
    exp_t e;
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    isSigned = sgn;
    start    = 1'b1;
    e.q = expQ; e.r = expR; e.dz = expDz; e.ov = expOv;
    e.lat = lat; e.startCycle = cycleCnt; e.id = id;
    sbQueue.push_back(e);
    doneTarget = doneSeen + 1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 32'hA5A5_5A5A;
    divisor  = 32'h0F0F_0F0F;
    isSigned = ~sgn;
  endtask

  task automatic waitForDone(input int maxCycles);
    int n = 0;
    while (doneSeen < doneTarget && n < maxCycles) begin
      @(negedge clk); #1;
      n++;
    end
    if (doneSeen < doneTarget) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL doneTimeout: got no done within %0d cycles, expected done", maxCycles);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; isSigned = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("resetCtrl", {28'd0, busy, done, divByZero, overflow}, 32'd0);
    checkOutput("resetQuotient", quotient, 32'd0);
    checkOutput("resetRemainder", remainder, 32'd0);

    // Unsigned 100/7 with busy window 1..34 and done at 35
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 35, 1);
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (busy !== ((i <= 34) ? 1'b1 : 1'b0)) busyBad++;
    end
    checkOutput("busyWindow", busyBad, 32'd0);
    waitForDone(5);

    // Signed cases
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 35, 2);
    waitForDone(60);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 35, 3);
    waitForDone(60);
    applyStimulus(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0, 35, 4);
    waitForDone(60);
    applyStimulus(32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 32'd0, 1'b0, 1'b0, 35, 5);
    waitForDone(60);

    // Divide by zero early out, plus a start in the DONE cycle that must be ignored
    applyStimulus(32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0, 2, 6);
    @(posedge clk); #1;
    dividend = 32'd9; divisor = 32'd3; isSigned = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (45) @(negedge clk);
    #1;
    checkOutput("startInDoneIgnored", doneSeen, doneTarget);
    applyStimulus(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 2, 7);
    waitForDone(60);

    // Signed overflow and the same operands unsigned (flags must clear)
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 2, 8);
    waitForDone(60);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 35, 9);
    waitForDone(60);

    // Start re-pulsed at cycle 10 with other operands is ignored
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 35, 10);
    repeat (9) @(posedge clk);
    #1;
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitForDone(60);

    // Reset at cycle 20 aborts the division and clears outputs
    baseline = doneSeen;
    @(posedge clk); #1;
    dividend = 32'd500; divisor = 32'd3; isSigned = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abortCtrl", {28'd0, busy, done, divByZero, overflow}, 32'd0);
    checkOutput("abortQuotient", quotient, 32'd0);
    checkOutput("abortRemainder", remainder, 32'd0);
    repeat (40) @(negedge clk);
    #1;
    checkOutput("noDoneAfterReset", doneSeen, baseline);

    // Full-range unsigned and back-to-back starts one cycle after done
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 35, 11);
    waitForDone(60);
    applyStimulus(32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0, 1'b0, 35, 12);
    waitForDone(60);
    applyStimulus(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0, 35, 13);
    waitForDone(60);
    applyStimulus(32'd77, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd77, 1'b1, 1'b0, 2, 14);
    waitForDone(60);

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", sbQueue.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
